// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter that time-shares one signed multiply-accumulate unit among NREQ requesters.
// Optional build macro MAC_RELU_EN clamps negative results to zero on res_data.
module mac_share_arbiter #(
    parameter int NREQ = 4,
    parameter int T    = 16,
    parameter int LOGL = 4,
    parameter int LOGR = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*LOGL-1:0] req_len,
    input  logic [NREQ*T-1:0]    req_bias,
    output logic [NREQ-1:0]      grant,
    input  logic [NREQ-1:0]      op_valid,
    input  logic [NREQ*T-1:0]    op_w,
    input  logic [NREQ*T-1:0]    op_x,
    output logic [NREQ-1:0]      op_ready,
    output logic                 res_valid,
    output logic [T-1:0]         res_data,
    output logic [LOGR-1:0]      res_id,
    input  logic                 res_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [NREQ-1:0]   grant_reg, grant_next;
    logic [LOGR-1:0]   g_reg, g_next;
    logic [LOGR-1:0]   ptr_reg, ptr_next;
    logic [T-1:0]      acc_reg, acc_next;
    logic [LOGL-1:0]   cnt_reg, cnt_next;

    logic [LOGL-1:0]   len_a  [NREQ];
    logic [T-1:0]      bias_a [NREQ];
    logic [T-1:0]      w_a    [NREQ];
    logic [T-1:0]      x_a    [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign len_a[gi]  = req_len[gi*LOGL +: LOGL];
            assign bias_a[gi] = req_bias[gi*T +: T];
            assign w_a[gi]    = op_w[gi*T +: T];
            assign x_a[gi]    = op_x[gi*T +: T];
        end
    endgenerate

    // Round-robin search starts just after the last served requester.
    logic            win_found;
    logic [LOGR-1:0] win_idx;
    logic [LOGR-1:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = LOGR'((int'(ptr_reg) + i) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    logic                  beat;
    logic signed [2*T-1:0] prod;

    assign beat = (state_reg == RUN) && op_valid[g_reg];
    assign prod = $signed(w_a[g_reg]) * $signed(x_a[g_reg]);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        g_next     = g_reg;
        ptr_next   = ptr_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next = RUN;
                    grant_next = NREQ'(1) << win_idx;
                    g_next     = win_idx;
                    acc_next   = bias_a[win_idx];
                    cnt_next   = (len_a[win_idx] == '0) ? LOGL'(1) : len_a[win_idx];
                end
            end
            RUN: begin
                if (beat) begin
                    acc_next = acc_reg + prod[T-1:0];
                    cnt_next = cnt_reg - LOGL'(1);
                    if (cnt_reg == LOGL'(1))
                        state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                    ptr_next   = g_reg;
                    grant_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            g_reg     <= '0;
            ptr_reg   <= LOGR'(NREQ-1);
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            g_reg     <= g_next;
            ptr_reg   <= ptr_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign grant     = grant_reg;
    assign op_ready  = (state_reg == RUN) ? grant_reg : '0;
    assign res_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign res_id    = g_reg;

`ifdef MAC_RELU_EN
    assign res_data = acc_reg[T-1] ? '0 : acc_reg;
`else
    assign res_data = acc_reg;
`endif

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed self-checking bench for mac_share_arbiter: arbitration order, MAC results,
// handshake hold, wrap-around, zero length and asynchronous reset.
module tb_mac_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_len;
    logic [63:0] req_bias;
    logic [3:0]  grant;
    logic [3:0]  op_valid;
    logic [63:0] op_w;
    logic [63:0] op_x;
    logic [3:0]  op_ready;
    logic        res_valid;
    logic [15:0] res_data;
    logic [1:0]  res_id;
    logic        res_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] s2_seq [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                4'b0001};

    mac_share_arbiter #(.NREQ(4), .T(16), .LOGL(4), .LOGR(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_bias  (req_bias),
        .grant     (grant),
        .op_valid  (op_valid),
        .op_w      (op_w),
        .op_x      (op_x),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic show_result();
        $display("result id=%0d data=%0d valid=%0b", res_id, $signed(res_data), res_valid);
    endtask

    initial begin
        reset = 1'b0; req_valid = '0; req_len = '0; req_bias = '0;
        op_valid = '0; op_w = '0; op_x = '0; res_ready = 1'b0;
        step(); step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_op_ready", 32'(op_ready), 32'h0);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_data", 32'(res_data), 32'h0);
        check("rst_res_id", 32'(res_id), 32'h0);
        reset = 1'b1;

        // Scenario 1: req0, len 3, bias -103
        req_valid = 4'b0001; req_len[3:0] = 4'd3; req_bias[15:0] = 16'hFF99;
        step();
        check("s1_grant", 32'(grant), 32'h1);
        check("s1_busy", 32'(busy), 32'h1);
        check("s1_op_ready", 32'(op_ready), 32'h1);
        req_valid = 4'b1000;
        op_valid = 4'b0001; op_w[15:0] = 16'd13; op_x[15:0] = 16'd2;
        step();
        req_valid = 4'b0000; op_w[15:0] = 16'd46; op_x[15:0] = 16'd1;
        step();
        check("s1_not_done", 32'(res_valid), 32'h0);
        op_w[15:0] = 16'd89; op_x[15:0] = 16'hFFFF;
        step();
        op_valid = '0;
        show_result();
        check("s1_res_valid", 32'(res_valid), 32'h1);
`ifdef MAC_RELU_EN
        check("s1_res_data", 32'(res_data), 32'h0);
`else
        check("s1_res_data", 32'(res_data), 32'hFF88);
`endif
        check("s1_res_id", 32'(res_id), 32'h0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("s1_grant_clr", 32'(grant), 32'h0);
        check("s1_idle", 32'(busy), 32'h0);

        // Scenario 4: req1, len 2, gaps interleaved; req0 operands must be ignored
        req_valid = 4'b0010; req_len[7:4] = 4'd2; req_bias[31:16] = 16'd0;
        op_valid = 4'b0001; op_w[15:0] = 16'd7; op_x[15:0] = 16'd7;
        step();
        check("s4_grant", 32'(grant), 32'h2);
        check("s4_op_ready", 32'(op_ready), 32'h2);
        req_valid = 4'b0000;
        step();
        op_valid = 4'b0011; op_w[31:16] = 16'd3; op_x[31:16] = 16'd4;
        step();
        op_valid = 4'b0001;
        step(); step();
        check("s4_not_done", 32'(res_valid), 32'h0);
        op_valid = 4'b0011; op_w[31:16] = 16'd5; op_x[31:16] = 16'd6;
        step();
        op_valid = '0;
        show_result();
        check("s4_res_valid", 32'(res_valid), 32'h1);
        check("s4_res_data", 32'(res_data), 32'h2A);
        check("s4_res_id", 32'(res_id), 32'h1);

        // Scenario 3: result held while res_ready low
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("s3_valid%0d", i), 32'(res_valid), 32'h1);
            check($sformatf("s3_data%0d", i), 32'(res_data), 32'h2A);
            check($sformatf("s3_id%0d", i), 32'(res_id), 32'h1);
            check($sformatf("s3_grant%0d", i), 32'(grant), 32'h2);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("s3_grant_clr", 32'(grant), 32'h0);

        // Scenario 5: two's complement wrap on req2
        req_valid = 4'b0100; req_len[11:8] = 4'd1; req_bias[47:32] = 16'h7FFF;
        step();
        check("s5_grant", 32'(grant), 32'h4);
        req_valid = 4'b0000;
        op_valid = 4'b0100; op_w[47:32] = 16'd1; op_x[47:32] = 16'd1;
        step();
        op_valid = '0;
        show_result();
        check("s5_res_valid", 32'(res_valid), 32'h1);
`ifdef MAC_RELU_EN
        check("s5_res_data", 32'(res_data), 32'h0);
`else
        check("s5_res_data", 32'(res_data), 32'h8000);
`endif
        check("s5_res_id", 32'(res_id), 32'h2);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Zero length behaves as one beat: req3, 5 + 2*3 = 11
        req_valid = 4'b1000; req_len[15:12] = 4'd0; req_bias[63:48] = 16'd5;
        step();
        check("len0_grant", 32'(grant), 32'h8);
        req_valid = 4'b0000;
        op_valid = 4'b1000; op_w[63:48] = 16'd2; op_x[63:48] = 16'd3;
        step();
        op_valid = '0;
        show_result();
        check("len0_res_valid", 32'(res_valid), 32'h1);
        check("len0_res_data", 32'(res_data), 32'hB);
        check("len0_res_id", 32'(res_id), 32'h3);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Scenario 2: all requesters held high from reset, len 1 each
        reset = 1'b0;
        req_valid = 4'b1111; req_len = 16'h1111; req_bias = '0;
        op_valid = 4'b1111; op_w = 64'h0001_0001_0001_0001; op_x = 64'h0001_0001_0001_0001;
        res_ready = 1'b1;
        step();
        check("s2_rst_grant", 32'(grant), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            $display("cycle %0d grant=%b res_valid=%0b res_id=%0d", i, grant, res_valid, res_id);
            check($sformatf("s2_grant%0d", i), 32'(grant), 32'(s2_seq[i]));
        end

        // Scenario 6: asynchronous reset mid-RUN on req2
        reset = 1'b0;
        #1;
        check("s6_pre_grant", 32'(grant), 32'h0);
        req_valid = 4'b0100; op_valid = '0; res_ready = 1'b0;
        reset = 1'b1;
        step();
        check("s6_grant_req2", 32'(grant), 32'h4);
        step();
        check("s6_run_busy", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("s6_async_grant", 32'(grant), 32'h0);
        check("s6_async_busy", 32'(busy), 32'h0);
        check("s6_async_op_ready", 32'(op_ready), 32'h0);
        req_valid = 4'b1000;
        reset = 1'b1;
        #1;
        check("s6_no_edge_grant", 32'(grant), 32'h0);
        step();
        check("s6_grant_req3", 32'(grant), 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_share_arbiter.md
MAC_SHARE_ARBITER -- requirements
Module: mac_share_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; T, default 16, data width; LOGL, default 4, burst-length width; LOGR, default 2, requester-ID width, equal to clog2(NREQ).
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all flops are rising-edge triggered.
REQ-003 Port reset SHALL be: input, 1 bit, asynchronous, active-low reset.
REQ-004 Port req_valid SHALL be: input, NREQ bits, burst request per requester.
REQ-005 Port req_len SHALL be: input, NREQ*LOGL bits, number of MAC beats per burst, per requester.
REQ-006 Port req_bias SHALL be: input, NREQ*T bits, signed initial accumulator value, per requester.
REQ-007 Port grant SHALL be: output, NREQ bits, one-hot or zero; marks the owner of the shared MAC.
REQ-008 Port op_valid SHALL be: input, NREQ bits, operand beat valid, per requester.
REQ-009 Port op_w SHALL be: input, NREQ*T bits, signed weight operand, per requester.
REQ-010 Port op_x SHALL be: input, NREQ*T bits, signed vector operand, per requester.
REQ-011 Port op_ready SHALL be: output, NREQ bits, operand accept; only the granted bit may be high.
REQ-012 Port res_valid SHALL be: output, 1 bit, result available.
REQ-013 Port res_data SHALL be: output, T bits, signed dot-product result.
REQ-014 Port res_id SHALL be: output, LOGR bits, index of the requester that owns res_data.
REQ-015 Port res_ready SHALL be: input, 1 bit, result consumer accept.
REQ-016 Port busy SHALL be: output, 1 bit, high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-018 IDLE -> RUN: when any req_valid bit is high, the winner SHALL be chosen round-robin, searching from ptr+1 upward with wrap.
REQ-019 On the IDLE->RUN edge: grant SHALL be set to the winner's one-hot; acc SHALL load the winner's req_bias; cnt SHALL load the winner's req_len.
REQ-020 Grant latency SHALL be exactly one cycle from a sampled req_valid.
REQ-021 In RUN, op_ready[g] SHALL be 1; a beat SHALL be accepted only when op_valid[g] && op_ready[g].
REQ-022 On each accepted beat, acc SHALL update to acc + (op_w[g]*op_x[g]), keeping the low T bits; wrap is two's complement, with no saturation; cnt SHALL decrement.
REQ-023 Cycles in RUN with op_valid[g]=0 SHALL leave acc and cnt unchanged.
REQ-024 RUN -> DONE SHALL occur on the accepted beat taken while cnt==1.
REQ-025 req_len==0 SHALL be treated as 1.
REQ-026 In DONE: res_valid SHALL be 1; res_data SHALL be the final acc (post-processed per REQ-036); res_id SHALL be g; grant SHALL remain held.
REQ-027 res_data and res_id SHALL be stable while res_valid && !res_ready.
REQ-028 DONE -> IDLE SHALL occur on res_ready; on that edge ptr <= g and grant SHALL clear.
REQ-029 Each burst SHALL be followed by one mandatory IDLE bubble cycle.
REQ-030 req_valid and operands from non-granted requesters SHALL be ignored.
REQ-031 Deassertion of req_valid[g] during RUN/DONE SHALL NOT abort the burst.
REQ-032 A requester whose req_valid drops before it is granted SHALL NOT be granted.
REQ-033 No requester SHALL wait more than NREQ-1 bursts while holding req_valid high.

Reset
REQ-034 When reset is low: state SHALL go to IDLE; grant, op_ready, res_valid and busy SHALL be 0; acc, cnt, res_data and res_id SHALL be 0; ptr SHALL be NREQ-1, so requester 0 wins first. All of this SHALL take effect immediately, including mid-RUN or mid-DONE, and the in-flight burst SHALL be discarded.
REQ-035 The first arbitration SHALL occur on the first rising clk edge after reset deasserts.

Configuration
REQ-036 Macro MAC_RELU_EN: when defined, res_data SHALL be 0 whenever the final acc is negative, and acc otherwise; when undefined, res_data SHALL equal acc unmodified. The macro SHALL NOT change latency or handshake behaviour.

Verification
REQ-037 Scenario 1: req0, len=3, bias=-103, beats (13,2), (46,1), (89,-1) -> res_valid with res_data=-120 and res_id=0; with MAC_RELU_EN defined, res_data=0.
REQ-038 Scenario 2: all four req_valid held high from reset, each len=1 -> grants in order 0,1,2,3,0, with one IDLE cycle between each.
REQ-039 Scenario 3: res_ready held low for 5 cycles in DONE -> res_valid, res_data and res_id stable, and grant does not change.
REQ-040 Scenario 4: req1, len=2, bias=0, beats (3,4) and (5,6) with 3 op_valid=0 gaps interleaved -> res_data=42 and res_id=1.
REQ-041 Scenario 5: bias=32767, len=1, beat (1,1) -> res_data=-32768; with MAC_RELU_EN defined, res_data=0.
REQ-042 Scenario 6: reset pulled low mid-RUN on req2 -> grant=0 and busy=0 without waiting for a clock edge; after release with only req3 valid, grant=4'b1000 one cycle later.
